// File: rtl/punct_encoder.sv
`default_nettype none
// ============================================================================
// Module      : punct_encoder
// Description : K=7 (133/171 octal) convolutional encoder with 802.11a
//               puncturing (1/2, 2/3, 3/4) on an AXI-Stream beat interface.
//               A single output register sits between the streams.
//               Optional tail-bit check enabled by the macro
//               PUNCT_ENCODER_TAIL_CHECK_EN (default: disabled, tail_err = 0).
// Revision    : 1.0 - initial release
// ============================================================================
module punct_encoder #(
    parameter int WIDTH = 24
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [WIDTH-1:0]     s_axis_tdata,
    input  logic [3:0]           s_axis_tuser,
    input  logic                 s_axis_tvalid,
    input  logic                 s_axis_tlast,
    output logic                 s_axis_tready,
    output logic [2*WIDTH-1:0]   m_axis_tdata,
    output logic [3:0]           m_axis_tuser,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    input  logic                 m_axis_tready,
    output logic                 tail_err
);

    // 802.11a SIGNAL-field rate codes
    localparam logic [3:0] RATE_6M  = 4'b1011;
    localparam logic [3:0] RATE_9M  = 4'b1111;
    localparam logic [3:0] RATE_12M = 4'b1010;
    localparam logic [3:0] RATE_18M = 4'b1110;
    localparam logic [3:0] RATE_24M = 4'b1001;
    localparam logic [3:0] RATE_36M = 4'b1101;
    localparam logic [3:0] RATE_48M = 4'b1000;
    localparam logic [3:0] RATE_54M = 4'b1100;

    localparam logic [1:0] MODE_R12 = 2'd0;
    localparam logic [1:0] MODE_R23 = 2'd1;
    localparam logic [1:0] MODE_R34 = 2'd2;

    localparam int PAIRS    = WIDTH / 2;
    localparam int TRIPLETS = WIDTH / 3;

    // r_state[0] holds the most recent input bit, r_state[5] the oldest
    logic [5:0]           r_state;
    logic [5:0]           w_next_state;
    logic [1:0]           w_mode;
    logic [WIDTH-1:0]     w_a;
    logic [WIDTH-1:0]     w_b;
    logic [2*WIDTH-1:0]   w_coded;
    logic                 w_accept;

    assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
    assign w_accept      = s_axis_tvalid && s_axis_tready;

    // Map the rate code to a puncturing mode; unknown codes fall back to 1/2
    always_comb begin
        w_mode = MODE_R12;
        case (s_axis_tuser)
            RATE_6M, RATE_12M, RATE_24M:           w_mode = MODE_R12;
            RATE_48M:                              w_mode = MODE_R23;
            RATE_9M, RATE_18M, RATE_36M, RATE_54M: w_mode = MODE_R34;
            default:                               w_mode = MODE_R12;
        endcase
    end

    // Run the mother code over every input bit, oldest (bit 0) first
    always_comb begin : conv
        logic [5:0] v_sr;
        v_sr = r_state;
        w_a  = '0;
        w_b  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_a[i] = s_axis_tdata[i] ^ v_sr[1] ^ v_sr[2] ^ v_sr[4] ^ v_sr[5];
            w_b[i] = s_axis_tdata[i] ^ v_sr[0] ^ v_sr[1] ^ v_sr[2] ^ v_sr[5];
            v_sr   = {v_sr[4:0], s_axis_tdata[i]};
        end
        w_next_state = v_sr;
    end

    // Puncture the A/B streams into an LSB-aligned word, unused bits zero
    always_comb begin
        w_coded = '0;
        case (w_mode)
            MODE_R23: begin
                for (int p = 0; p < PAIRS; p++) begin
                    w_coded[3*p]     = w_a[2*p];
                    w_coded[3*p + 1] = w_b[2*p];
                    w_coded[3*p + 2] = w_a[2*p + 1];
                end
            end
            MODE_R34: begin
                for (int t = 0; t < TRIPLETS; t++) begin
                    w_coded[4*t]     = w_a[3*t];
                    w_coded[4*t + 1] = w_b[3*t];
                    w_coded[4*t + 2] = w_a[3*t + 1];
                    w_coded[4*t + 3] = w_b[3*t + 2];
                end
            end
            default: begin
                for (int i = 0; i < WIDTH; i++) begin
                    w_coded[2*i]     = w_a[i];
                    w_coded[2*i + 1] = w_b[i];
                end
            end
        endcase
    end

    // Output register and encoder state; a tlast beat restarts from zero state
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state       <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
        end else if (w_accept) begin
            r_state       <= s_axis_tlast ? 6'd0 : w_next_state;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= s_axis_tlast;
            m_axis_tdata  <= w_coded;
            m_axis_tuser  <= s_axis_tuser;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

`ifdef PUNCT_ENCODER_TAIL_CHECK_EN
    logic r_tail_err;

    // Sticky flag: a packet must end with six zero tail bits
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_tail_err <= 1'b0;
        end else if (w_accept && s_axis_tlast && (|s_axis_tdata[WIDTH-1:WIDTH-6])) begin
            r_tail_err <= 1'b1;
        end
    end

    assign tail_err = r_tail_err;
`else
    assign tail_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_punct_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_punct_encoder
// Description : Self-checking bench for punct_encoder (WIDTH = 24).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_punct_encoder;

    localparam logic [3:0] R6  = 4'b1011;
    localparam logic [3:0] R9  = 4'b1111;
    localparam logic [3:0] R24 = 4'b1001;
    localparam logic [3:0] R48 = 4'b1000;
    localparam logic [3:0] R54 = 4'b1100;

    logic        clk;
    logic        areset;
    logic [23:0] s_data;
    logic [3:0]  s_user;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [47:0] m_data;
    logic [3:0]  m_user;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;
    logic        tail_err;

    int total = 0;
    int bad   = 0;
    int beats = 0;

    typedef struct {
        logic [47:0] data;
        logic [3:0]  user;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    logic [5:0]  hist = '0;   // model history, bit 5 = most recent input

    punct_encoder #(.WIDTH(24)) dut (
        .aclk          (clk),
        .areset        (areset),
        .s_axis_tdata  (s_data),
        .s_axis_tuser  (s_user),
        .s_axis_tvalid (s_valid),
        .s_axis_tlast  (s_last),
        .s_axis_tready (s_ready),
        .m_axis_tdata  (m_data),
        .m_axis_tuser  (m_user),
        .m_axis_tvalid (m_valid),
        .m_axis_tlast  (m_last),
        .m_axis_tready (m_ready),
        .tail_err      (tail_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // 0 = rate 1/2, 1 = rate 2/3, 2 = rate 3/4
    function automatic int kind_of(input logic [3:0] r);
        case (r)
            4'b1000:                            return 1;
            4'b1111, 4'b1110, 4'b1101, 4'b1100: return 2;
            default:                            return 0;
        endcase
    endfunction

    function automatic int valid_bits(input logic [3:0] r);
        case (kind_of(r))
            1:       return 36;
            2:       return 32;
            default: return 48;
        endcase
    endfunction

    // Serial reference: generator-polynomial parity over a 7-bit window,
    // then a keep/drop pattern applied to the A/B stream
    function automatic logic [47:0] enc(input logic [3:0] r, input logic [23:0] d,
                                        input logic [5:0] h_in, output logic [5:0] h_out);
        logic [47:0] res;
        logic [6:0]  w;
        logic [5:0]  h;
        logic        a, b, ka, kb;
        int          ptr, k, ph;
        res = '0; h = h_in; ptr = 0; k = kind_of(r);
        for (int i = 0; i < 24; i++) begin
            w  = {d[i], h};
            a  = ^(w & 7'o133);
            b  = ^(w & 7'o171);
            h  = w[6:1];
            ph = (k == 0) ? 0 : ((k == 1) ? (i % 2) : (i % 3));
            ka = !(k == 2 && ph == 2);
            kb = (k == 0) || (ph == 0) || (k == 2 && ph == 2);
            if (ka) begin res[ptr] = a; ptr++; end
            if (kb) begin res[ptr] = b; ptr++; end
        end
        h_out = h;
        return res;
    endfunction

    // Drive one beat at a falling edge together with m_ready, wait for the
    // handshake, queue the expected output, return just after the accept edge
    task automatic send(input logic [3:0] r, input logic [23:0] d, input logic l,
                        input logic mr, input logic use_exp, input logic [47:0] xp,
                        output int waited);
        exp_t        e;
        logic [5:0]  hn;
        logic [47:0] mdl;
        @(negedge clk);
        s_valid = 1'b1; s_data = d; s_user = r; s_last = l; m_ready = mr;
        #1;
        waited = 0;
        while (!s_ready && waited < 50) begin
            @(negedge clk); #1; waited++;
        end
        if (!s_ready) begin
            check("accept_timeout", 48'(s_ready), 48'd1);
        end else begin
            mdl    = enc(r, d, hist, hn);
            hist   = l ? 6'd0 : hn;
            e.data = use_exp ? xp : mdl;
            e.user = r;
            e.last = l;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        check("latency_valid", 48'(m_valid), 48'd1);
    endtask

    task automatic drain(input int want_beats, input int beats0);
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk); #3; n++;
        end
        if (sb.size() != 0) check("drain_timeout", 48'(sb.size()), 48'd0);
        check("beat_count", 48'(beats - beats0), 48'(want_beats));
    endtask

    // Scoreboard: outputs are sampled between the falling and rising edges,
    // where the handshake seen is the one the next rising edge completes
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (m_valid && m_ready && !areset) begin
                beats++;
                if (sb.size() == 0) begin
                    check("unexpected_beat", m_data, 48'd0);
                end else begin
                    e = sb.pop_front();
                    check("tdata", m_data, e.data);
                    check("tuser", 48'(m_user), 48'(e.user));
                    check("tlast", 48'(m_last), 48'(e.last));
                    check("upper_zero", m_data >> valid_bits(m_user), 48'd0);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  rate;
        logic [23:0] data;
        logic        last;
        int          hs;       // 0: valid before ready, 1: ready first, 2: together
        logic        has_exp;
        logic [47:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int w, b0;
        logic [47:0] hold;
        logic [5:0]  hn;

        vecs[0] = '{R6,      24'h000c8d, 1'b1, 0, 1'b1, 48'h000e7c40858b};
        vecs[1] = '{R6,      24'h000c8d, 1'b1, 1, 1'b1, 48'h000e7c40858b};
        vecs[2] = '{R6,      24'h000c8d, 1'b1, 2, 1'b1, 48'h000e7c40858b};
        vecs[3] = '{R48,     24'h000000, 1'b0, 2, 1'b1, 48'h000000000000};
        vecs[4] = '{R48,     24'h000001, 1'b1, 2, 1'b1, 48'h00000000073b};
        vecs[5] = '{R54,     24'h5a3c96, 1'b0, 2, 1'b0, 48'h0};
        vecs[6] = '{R24,     24'hfedcba, 1'b0, 2, 1'b0, 48'h0};
        vecs[7] = '{4'b0000, 24'h123456, 1'b1, 2, 1'b0, 48'h0};

        areset = 1'b1; s_valid = 1'b0; s_data = '0; s_user = '0; s_last = 1'b0; m_ready = 1'b0;
        #12;
        check("rst_m_valid", 48'(m_valid), 48'd0);
        check("rst_s_ready", 48'(s_ready), 48'd1);
        check("rst_m_tdata", m_data, 48'd0);
        check("rst_m_tuser", 48'(m_user), 48'd0);
        check("rst_m_tlast", 48'(m_last), 48'd0);
        check("rst_tail_err", 48'(tail_err), 48'd0);
        @(negedge clk); areset = 1'b0;

        // Table vectors with three handshake orders and rate changes
        for (int i = 0; i < 8; i++) begin
            b0 = beats;
            if (vecs[i].hs == 1) begin
                @(negedge clk); m_ready = 1'b1;
            end
            send(vecs[i].rate, vecs[i].data, vecs[i].last, (vecs[i].hs != 0),
                 vecs[i].has_exp, vecs[i].exp, w);
            if (vecs[i].hs == 0) begin
                repeat (3) @(negedge clk);
                #1 check("hold_valid", 48'(m_valid), 48'd1);
                @(negedge clk); m_ready = 1'b1;
            end
            if (i == 4) begin
                #1 check("r23_bits", 48'(m_data[2:0]), 48'd3);
            end
            drain(1, b0);
        end

        // Rate 3/4 back-to-back burst
        b0 = beats;
        for (int k = 0; k < 10; k++) begin
            send(R9, 24'($urandom), 1'b0, 1'b1, 1'b0, 48'h0, w);
            if (k > 0) check("no_bubble", 48'(w), 48'd0);
        end
        drain(10, b0);

        // Backpressure: output held five cycles, then drain and load same edge
        b0 = beats;
        hold = enc(R6, 24'h9b3e01, hist, hn);
        send(R6, 24'h9b3e01, 1'b0, 1'b0, 1'b0, 48'h0, w);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            check("bp_s_ready", 48'(s_ready), 48'd0);
            check("bp_stable", m_data, hold);
        end
        send(R48, 24'h0f0f33, 1'b0, 1'b1, 1'b0, 48'h0, w);
        check("bp_same_edge", 48'(w), 48'd0);
        drain(2, b0);

        // Tail bits: nonzero tail on a tlast beat, next beat from zero state
        b0 = beats;
        send(R6, 24'h040000, 1'b1, 1'b1, 1'b0, 48'h0, w);
`ifdef PUNCT_ENCODER_TAIL_CHECK_EN
        check("tail_err_set", 48'(tail_err), 48'd1);
`else
        check("tail_err_off", 48'(tail_err), 48'd0);
`endif
        send(R6, 24'h000001, 1'b0, 1'b1, 1'b0, 48'h0, w);
        drain(2, b0);
`ifdef PUNCT_ENCODER_TAIL_CHECK_EN
        check("tail_err_sticky", 48'(tail_err), 48'd1);
`else
        check("tail_err_stays0", 48'(tail_err), 48'd0);
`endif

        // Reset mid-packet drops the pending beat and the encoder state
        send(R54, 24'h777777, 1'b0, 1'b0, 1'b0, 48'h0, w);
        #3 areset = 1'b1;
        #1;
        check("mid_rst_valid", 48'(m_valid), 48'd0);
        check("mid_rst_ready", 48'(s_ready), 48'd1);
        check("mid_rst_tdata", m_data, 48'd0);
        check("mid_rst_tail", 48'(tail_err), 48'd0);
        sb.delete();
        hist = '0;
        @(negedge clk); areset = 1'b0;
        b0 = beats;
        send(R6, 24'h000c8d, 1'b0, 1'b1, 1'b1, 48'h000e7c40858b, w);
        drain(1, b0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
